// File: rtl/ooo_pkg.sv
// Shared out-of-order core sizing: architectural/physical register counts and tag types,
// used by both the rename map table and the free list.
package ooo_pkg;

    localparam int ARCH_REGS = 32;
    localparam int PHYS_REGS = 64;
    localparam int PHYS_W    = $clog2(PHYS_REGS);

    typedef logic [PHYS_W-1:0] phys_tag_t;
    typedef logic [PHYS_W:0]   phys_cnt_t;

endpackage

// File: rtl/free_list_if.sv
// Free-list handshake bundle: rename-stage allocation, commit/recover returns, flush and status.
interface free_list_if;
    import ooo_pkg::*;

    logic      alloc_req;
    logic      alloc_valid;
    phys_tag_t alloc_pd;
    logic      commit_free_valid;
    phys_tag_t commit_free_pd;
    logic      recover_free_valid;
    phys_tag_t recover_free_pd;
    logic      flush_valid;
    phys_cnt_t free_count;
    logic      overflow_err;

    modport master (
        output alloc_req, commit_free_valid, commit_free_pd,
               recover_free_valid, recover_free_pd, flush_valid,
        input  alloc_valid, alloc_pd, free_count, overflow_err
    );

    modport slave (
        input  alloc_req, commit_free_valid, commit_free_pd,
               recover_free_valid, recover_free_pd, flush_valid,
        output alloc_valid, alloc_pd, free_count, overflow_err
    );

endinterface

// File: rtl/free_list.sv
// Physical register free list: circular FIFO of free tags with one pop and up to two pushes
// per cycle; flush and reset reload the identity image (tags ARCH_REGS..PHYS_REGS-1).
module free_list #(
    parameter int ARCH_REGS = ooo_pkg::ARCH_REGS,
    parameter int PHYS_REGS = ooo_pkg::PHYS_REGS,
    parameter int PHYS_W    = $clog2(PHYS_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_req,
    output logic              alloc_valid,
    output logic [PHYS_W-1:0] alloc_pd,
    input  logic              commit_free_valid,
    input  logic [PHYS_W-1:0] commit_free_pd,
    input  logic              recover_free_valid,
    input  logic [PHYS_W-1:0] recover_free_pd,
    input  logic              flush_valid,
    output logic [PHYS_W:0]   free_count,
    output logic              overflow_err
);

    localparam logic [PHYS_W-1:0] TAIL_INIT = PHYS_W'(PHYS_REGS - ARCH_REGS);
    localparam logic [PHYS_W:0]   FREE_INIT = (PHYS_W + 1)'(PHYS_REGS - ARCH_REGS);
    localparam logic [PHYS_W+1:0] CAPACITY  = (PHYS_W + 2)'(PHYS_REGS - 1);

    logic [PHYS_W-1:0] mem_q [PHYS_REGS];
    logic [PHYS_W-1:0] mem_d [PHYS_REGS];
    logic [PHYS_W-1:0] head_q, head_d;
    logic [PHYS_W-1:0] tail_q, tail_d;
    logic [PHYS_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;

    logic              pop;
    logic              commit_ok;
    logic              recover_ok;
    logic [PHYS_W+1:0] occupancy;

    function automatic logic [PHYS_W-1:0] image_entry(input int idx);
        if (idx < PHYS_REGS - ARCH_REGS) begin
            return PHYS_W'(ARCH_REGS + idx);
        end
        return '0;
    endfunction

    // Explicit wrap so non-power-of-two depths still behave as a modulo ring.
    function automatic logic [PHYS_W-1:0] ptr_inc(input logic [PHYS_W-1:0] ptr);
        return (ptr == PHYS_W'(PHYS_REGS - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign alloc_valid  = (count_q != '0);
    assign alloc_pd     = mem_q[head_q];
    assign free_count   = count_q;
    assign overflow_err = overflow_q;

    always_comb begin
        mem_d      = mem_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        pop        = 1'b0;
        commit_ok  = 1'b0;
        recover_ok = 1'b0;
        occupancy  = {1'b0, count_q};

        if (flush_valid) begin
            for (int i = 0; i < PHYS_REGS; i++) begin
                mem_d[i] = image_entry(i);
            end
            head_d  = '0;
            tail_d  = TAIL_INIT;
            count_d = FREE_INIT;
        end else begin
            pop       = alloc_req && alloc_valid;
            occupancy = {1'b0, count_q} - {{(PHYS_W + 1){1'b0}}, pop};

            // Commit is admitted before recover, so near capacity the recover push is the one dropped.
            if (commit_free_valid && (commit_free_pd != '0)) begin
                if (occupancy < CAPACITY) begin
                    commit_ok = 1'b1;
                    occupancy = occupancy + 1'b1;
                end else begin
                    overflow_d = 1'b1;
                end
            end
            if (recover_free_valid && (recover_free_pd != '0)) begin
                if (occupancy < CAPACITY) begin
                    recover_ok = 1'b1;
                    occupancy  = occupancy + 1'b1;
                end else begin
                    overflow_d = 1'b1;
                end
            end

            if (commit_ok) begin
                mem_d[tail_q] = commit_free_pd;
            end
            if (recover_ok) begin
                mem_d[commit_ok ? ptr_inc(tail_q) : tail_q] = recover_free_pd;
            end

            if (commit_ok && recover_ok) begin
                tail_d = ptr_inc(ptr_inc(tail_q));
            end else if (commit_ok || recover_ok) begin
                tail_d = ptr_inc(tail_q);
            end
            if (pop) begin
                head_d = ptr_inc(head_q);
            end
            count_d = occupancy[PHYS_W:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PHYS_REGS; i++) begin
                mem_q[i] <= image_entry(i);
            end
            head_q     <= '0;
            tail_q     <= TAIL_INIT;
            count_q    <= FREE_INIT;
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_free_list.sv
// Directed self-checking bench for free_list: drain, no-bypass, dual push, flush priority,
// overflow stickiness and pointer wrap-around against hand-computed tag sequences.
module tb_free_list;
    import ooo_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    free_list_if fl ();

    free_list dut (
        .clk                (clk),
        .rst                (rst),
        .alloc_req          (fl.alloc_req),
        .alloc_valid        (fl.alloc_valid),
        .alloc_pd           (fl.alloc_pd),
        .commit_free_valid  (fl.commit_free_valid),
        .commit_free_pd     (fl.commit_free_pd),
        .recover_free_valid (fl.recover_free_valid),
        .recover_free_pd    (fl.recover_free_pd),
        .flush_valid        (fl.flush_valid),
        .free_count         (fl.free_count),
        .overflow_err       (fl.overflow_err)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge, half a cycle from the active edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        fl.alloc_req          = 1'b0;
        fl.commit_free_valid  = 1'b0;
        fl.commit_free_pd     = '0;
        fl.recover_free_valid = 1'b0;
        fl.recover_free_pd    = '0;
        fl.flush_valid        = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (fl.alloc_valid !== 1'b1) begin
            failures++;
            $display("FAIL reset_valid got=%0b want=1", fl.alloc_valid);
        end
        checks++;
        if (fl.alloc_pd !== 6'd32) begin
            failures++;
            $display("FAIL reset_pd got=%0d want=32", fl.alloc_pd);
        end
        checks++;
        if (fl.free_count !== 7'd32) begin
            failures++;
            $display("FAIL reset_count got=%0d want=32", fl.free_count);
        end
        checks++;
        if (fl.overflow_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_ovf got=%0b want=0", fl.overflow_err);
        end
        rst = 1'b0;
    endtask

    task automatic test_drain();
        logic [PHYS_W-1:0] want;
        for (int i = 0; i < 32; i++) begin
            fl.alloc_req = 1'b1;
            want = 6'(32 + i);
            checks++;
            if (fl.alloc_valid !== 1'b1 || fl.alloc_pd !== want) begin
                failures++;
                $display("FAIL drain_pd[%0d] got=%0d/%0b want=%0d/1", i, fl.alloc_pd, fl.alloc_valid, want);
            end
            step();
        end
        checks++;
        if (fl.alloc_valid !== 1'b0 || fl.free_count !== 7'd0) begin
            failures++;
            $display("FAIL drain_empty got=%0b/%0d want=0/0", fl.alloc_valid, fl.free_count);
        end
        step();
        checks++;
        if (fl.free_count !== 7'd0) begin
            failures++;
            $display("FAIL empty_req_ignored got=%0d want=0", fl.free_count);
        end
        clear_inputs();
    endtask

    task automatic test_no_bypass();
        fl.commit_free_valid = 1'b1;
        fl.commit_free_pd    = 6'd5;
        checks++;
        if (fl.alloc_valid !== 1'b0) begin
            failures++;
            $display("FAIL no_bypass_same got=%0b want=0", fl.alloc_valid);
        end
        step();
        clear_inputs();
        checks++;
        if (fl.alloc_valid !== 1'b1 || fl.alloc_pd !== 6'd5 || fl.free_count !== 7'd1) begin
            failures++;
            $display("FAIL no_bypass_next got=%0b/%0d/%0d want=1/5/1", fl.alloc_valid, fl.alloc_pd, fl.free_count);
        end
    endtask

    task automatic test_dual_push();
        logic [PHYS_W-1:0] want;
        fl.flush_valid = 1'b1;
        step();
        clear_inputs();
        fl.alloc_req = 1'b1;
        repeat (22) step();
        fl.alloc_req = 1'b0;
        checks++;
        if (fl.free_count !== 7'd10 || fl.alloc_pd !== 6'd54) begin
            failures++;
            $display("FAIL dual_setup got=%0d/%0d want=10/54", fl.free_count, fl.alloc_pd);
        end
        fl.alloc_req          = 1'b1;
        fl.commit_free_valid  = 1'b1;
        fl.commit_free_pd     = 6'd7;
        fl.recover_free_valid = 1'b1;
        fl.recover_free_pd    = 6'd40;
        step();
        clear_inputs();
        checks++;
        if (fl.free_count !== 7'd11) begin
            failures++;
            $display("FAIL dual_count got=%0d want=11", fl.free_count);
        end
        for (int i = 0; i < 11; i++) begin
            want = (i < 9) ? 6'(55 + i) : ((i == 9) ? 6'd7 : 6'd40);
            fl.alloc_req = 1'b1;
            checks++;
            if (fl.alloc_pd !== want) begin
                failures++;
                $display("FAIL dual_order[%0d] got=%0d want=%0d", i, fl.alloc_pd, want);
            end
            step();
        end
        clear_inputs();
    endtask

    task automatic test_flush();
        fl.flush_valid = 1'b1;
        step();
        clear_inputs();
        for (int i = 0; i < 20; i++) begin
            fl.alloc_req          = 1'b1;
            fl.commit_free_valid  = 1'b1;
            fl.commit_free_pd     = 6'd0;
            fl.recover_free_valid = 1'b1;
            fl.recover_free_pd    = 6'd0;
            step();
        end
        clear_inputs();
        checks++;
        if (fl.free_count !== 7'd12 || fl.alloc_pd !== 6'd52) begin
            failures++;
            $display("FAIL zero_push_ignored got=%0d/%0d want=12/52", fl.free_count, fl.alloc_pd);
        end
        fl.flush_valid       = 1'b1;
        fl.alloc_req         = 1'b1;
        fl.commit_free_valid = 1'b1;
        fl.commit_free_pd    = 6'd9;
        step();
        clear_inputs();
        checks++;
        if (fl.free_count !== 7'd32 || fl.alloc_pd !== 6'd32 || fl.alloc_valid !== 1'b1) begin
            failures++;
            $display("FAIL flush_image got=%0d/%0d/%0b want=32/32/1", fl.free_count, fl.alloc_pd, fl.alloc_valid);
        end
        fl.alloc_req         = 1'b1;
        fl.commit_free_valid = 1'b1;
        fl.commit_free_pd    = 6'd3;
        step();
        clear_inputs();
        checks++;
        if (fl.free_count !== 7'd32 || fl.alloc_pd !== 6'd33) begin
            failures++;
            $display("FAIL flush_after got=%0d/%0d want=32/33", fl.free_count, fl.alloc_pd);
        end
        fl.alloc_req = 1'b1;
        repeat (31) step();
        checks++;
        if (fl.alloc_pd !== 6'd3 || fl.free_count !== 7'd1) begin
            failures++;
            $display("FAIL flush_tail got=%0d/%0d want=3/1", fl.alloc_pd, fl.free_count);
        end
        clear_inputs();
    endtask

    task automatic test_overflow();
        logic [PHYS_W-1:0] want;
        fl.flush_valid = 1'b1;
        step();
        clear_inputs();
        for (int i = 1; i <= 30; i++) begin
            fl.commit_free_valid = 1'b1;
            fl.commit_free_pd    = 6'(i);
            step();
        end
        clear_inputs();
        checks++;
        if (fl.free_count !== 7'd62 || fl.overflow_err !== 1'b0) begin
            failures++;
            $display("FAIL ovf_fill got=%0d/%0b want=62/0", fl.free_count, fl.overflow_err);
        end
        fl.commit_free_valid  = 1'b1;
        fl.commit_free_pd     = 6'd31;
        fl.recover_free_valid = 1'b1;
        fl.recover_free_pd    = 6'd50;
        step();
        clear_inputs();
        checks++;
        if (fl.free_count !== 7'd63 || fl.overflow_err !== 1'b1) begin
            failures++;
            $display("FAIL ovf_dual got=%0d/%0b want=63/1", fl.free_count, fl.overflow_err);
        end
        fl.commit_free_valid = 1'b1;
        fl.commit_free_pd    = 6'd51;
        step();
        clear_inputs();
        checks++;
        if (fl.free_count !== 7'd63) begin
            failures++;
            $display("FAIL ovf_full got=%0d want=63", fl.free_count);
        end
        for (int i = 0; i < 63; i++) begin
            want = (i < 32) ? 6'(32 + i) : 6'(i - 31);
            fl.alloc_req = 1'b1;
            checks++;
            if (fl.alloc_pd !== want) begin
                failures++;
                $display("FAIL ovf_order[%0d] got=%0d want=%0d", i, fl.alloc_pd, want);
            end
            step();
        end
        clear_inputs();
        checks++;
        if (fl.free_count !== 7'd0 || fl.overflow_err !== 1'b1) begin
            failures++;
            $display("FAIL ovf_drained got=%0d/%0b want=0/1", fl.free_count, fl.overflow_err);
        end
        fl.flush_valid = 1'b1;
        step();
        clear_inputs();
        checks++;
        if (fl.free_count !== 7'd32 || fl.overflow_err !== 1'b1) begin
            failures++;
            $display("FAIL ovf_flush got=%0d/%0b want=32/1", fl.free_count, fl.overflow_err);
        end
        fl.alloc_req         = 1'b1;
        fl.commit_free_valid = 1'b1;
        fl.commit_free_pd    = 6'd12;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (fl.free_count !== 7'd32 || fl.alloc_pd !== 6'd32 || fl.overflow_err !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got=%0d/%0d/%0b want=32/32/0", fl.free_count, fl.alloc_pd, fl.overflow_err);
        end
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        checks++;
        if (fl.free_count !== 7'd32 || fl.alloc_pd !== 6'd32) begin
            failures++;
            $display("FAIL reset_abandon got=%0d/%0d want=32/32", fl.free_count, fl.alloc_pd);
        end
    endtask

    task automatic test_wrap();
        logic [PHYS_W-1:0] model_q[$];
        logic [PHYS_W-1:0] tag;
        for (int i = 0; i < 32; i++) begin
            model_q.push_back(6'(32 + i));
        end
        for (int c = 0; c < 200; c++) begin
            tag = model_q.pop_front();
            model_q.push_back(tag);
            checks++;
            if (fl.alloc_pd !== tag || fl.free_count !== 7'd32) begin
                failures++;
                $display("FAIL wrap[%0d] got=%0d/%0d want=%0d/32", c, fl.alloc_pd, fl.free_count, tag);
            end
            fl.alloc_req         = 1'b1;
            fl.commit_free_valid = 1'b1;
            fl.commit_free_pd    = tag;
            step();
        end
        clear_inputs();
        checks++;
        if (fl.free_count !== 7'd32 || fl.alloc_pd !== model_q[0]) begin
            failures++;
            $display("FAIL wrap_end got=%0d/%0d want=32/%0d", fl.free_count, fl.alloc_pd, model_q[0]);
        end
    endtask

    initial begin
        test_reset();
        test_drain();
        test_no_bypass();
        test_dual_push();
        test_flush();
        test_overflow();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
